vpq_delay_monitor: RTL and testbench
====================================

// Module: vpq_delay_monitor
// PURPOSE
//  Synthesizable per-port, per-priority latency/throughput monitor for the N-port, P-priority
//  VPQ + fiSLIP switch. Counts frames written into and read out of each input's VPQs, computes
//  queueing delay (dequeue time - stored arrival stamp), and keeps min/max/total per (port, priority).
//  Stats are read through a registered select/readout port. Sits beside virtual_priority_queues.
// PARAMETERS
//  PORT      8   number of switch ports (N)
//  PRIORITY  4   number of priority classes (P); i_rd_priority is one-hot of this width
//  WIDTH     32  timestamp / per-counter width (W)
//  HIST_BINS 8   histogram bins per (port, priority), power of 2; used only with VPQ_DELAY_HIST_EN
//  HIST_SHIFT 3  bin index = delay >> HIST_SHIFT, clamped to HIST_BINS-1
// PORTS
//  clk            in   1            system clock
//  reset          in   1            synchronous, active-high reset
//  i_clear        in   1            synchronous clear of all statistics (time base keeps running)
//  i_wr           in   PORT         frame enqueued at input port i
//  i_wr_priority  in   PORT*PRIORITY one-hot enqueue priority, slice i for port i
//  i_rd           in   PORT         frame dequeued at input port i
//  i_rd_priority  in   PORT*PRIORITY one-hot dequeue priority, slice i for port i
//  i_data         in   PORT*WIDTH   arrival stamp leaving the VPQ with i_rd, slice i for port i
//  o_now          out  WIDTH        free-running time base; producers stamp frames with it
//  i_sel_port     in   $clog2(PORT) readout port select
//  i_sel_pri      in   $clog2(PRIORITY) readout priority select
//  i_sel_bin      in   $clog2(HIST_BINS) readout histogram bin (ignored without macro)
//  o_cnt_in       out  WIDTH        frames enqueued for selected (port, pri)
//  o_cnt_out      out  WIDTH        frames dequeued for selected (port, pri)
//  o_min_delay    out  WIDTH        minimum delay; all-ones when o_cnt_out==0
//  o_max_delay    out  WIDTH        maximum delay
//  o_total_delay  out  2*WIDTH      sum of delays
//  o_hist         out  WIDTH        histogram count of selected bin (0 without macro)
//  o_err          out  1            sticky: a non-one-hot priority accompanied i_wr or i_rd
// BEHAVIOUR
//  - Reset: o_now=0, all cnt/max/total/hist=0, min=all-ones, o_err=0, all readout outputs = reset values.
//  - o_now increments by 1 every cycle mod 2^WIDTH; not affected by i_clear.
//  - Delay = (o_now - i_data) mod 2^WIDTH, sampled in the i_rd cycle; correct across time-base wrap
//    provided true delay < 2^WIDTH.
//  - i_rd at port i, pri p (one-hot bit p): cnt_out+1, total+=delay, min=min(min,delay),
//    max=max(max,delay); all updates visible together one cycle later.
//  - i_wr at port i, pri p: cnt_in+1. Wr and rd on same port/cycle both take effect.
//  - All PORT ports update independently in the same cycle; no arbitration, no back-pressure.
//  - Counters and total saturate at all-ones; never wrap.
//  - Priority zero-hot or multi-hot with its strobe: event dropped, o_err set (cleared only by reset/i_clear).
//  - i_clear: all stats back to reset values next cycle; an event in the i_clear cycle is discarded.
//  - reset mid-operation: identical to power-up reset, o_now restarts at 0.
//  - Readout: outputs are registered; value reflects select inputs and stat state of previous cycle
//    (1-cycle latency); an event updating the selected entry shows two cycles after the event.
// CONFIGURATION
//  VPQ_DELAY_HIST_EN defined: per (port, pri) HIST_BINS saturating counters; each i_rd increments
//    bin min(delay>>HIST_SHIFT, HIST_BINS-1); cleared by reset/i_clear; readable via i_sel_bin/o_hist.
//  Not defined: no histogram storage; o_hist tied to 0; i_sel_bin unused.
// STRUCTURE
//  - Shared package vpq_stats_pkg: saturating-add function, one-hot-valid/one-hot-to-index
//    functions, stat-record struct {cnt_in, cnt_out, min, max, total}.
//  - Sub-module vpq_delay_port_stats: one instance per port holding PRIORITY records (and histogram);
//    top holds time base, o_err, and readout mux.
// TESTING
//  - Reset, no traffic: o_now counts 0,1,2..; readout any (port,pri) -> cnt 0, min 32'hffffffff, max 0.
//  - Port 2 pri 1: wr at now=10, rd with i_data=10 at now=25 -> cnt_in=1, cnt_out=1, min=max=total=15.
//  - Wrap: i_data=32'hffff_fff0 read at o_now=0x10 -> delay 0x20 recorded, not a huge value.
//  - All 8 ports rd simultaneously, delays 1..8 -> each port's record holds its own delay; no loss.
//  - i_rd_priority=4'b0110 with i_rd -> o_err=1, stats unchanged; i_clear with rd in same cycle ->
//    all stats reset, o_err=0, event not counted.
//  - Saturation: force cnt_out to 32'hffff_fffe, two rds -> stays 32'hffff_ffff. With
//    VPQ_DELAY_HIST_EN, delays 3, 9, 200 (SHIFT=3) -> bins 0, 1, 7 each =1.

Source files
------------

// File: rtl/vpq_stats_pkg.sv
// Shared types and helpers for the VPQ delay monitor: stat record, saturating adds,
// one-hot checks. Record fields are sized for WIDTH <= MAX_W; unused high bits stay zero.
package vpq_stats_pkg;

    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W-1:0]   stat_w_t;
    typedef logic [2*MAX_W-1:0] stat_2w_t;

    typedef struct packed {
        stat_w_t  cnt_in;
        stat_w_t  cnt_out;
        stat_w_t  min_d;
        stat_w_t  max_d;
        stat_2w_t total;
    } stat_rec_t;

    function automatic logic [63:0] ones(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [63:0] lim;
        lim = ones(w);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

    function automatic stat_w_t sat_inc(input stat_w_t a, input int unsigned w);
        logic [63:0] r;
        r = sat_add({32'd0, a}, 64'd1, w);
        return r[MAX_W-1:0];
    endfunction

    function automatic stat_2w_t sat_acc(input stat_2w_t a, input stat_w_t b, input int unsigned w);
        return sat_add(a, {32'd0, b}, w);
    endfunction

    function automatic logic onehot_valid(input logic [31:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int unsigned onehot_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (v[k]) idx = k;
        end
        return idx;
    endfunction

    function automatic stat_rec_t rec_init(input int unsigned w);
        stat_rec_t   r;
        logic [63:0] m;
        m       = ones(w);
        r       = '0;
        r.min_d = m[MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/vpq_delay_monitor_if.sv
// Event and readout bus of vpq_delay_monitor; master drives events/selects, slave is the monitor.
interface vpq_delay_monitor_if #(
    parameter int unsigned PORT      = 8,
    parameter int unsigned PRIORITY  = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned HIST_BINS = 8
);
    localparam int unsigned PORT_W = (PORT > 1) ? $clog2(PORT) : 1;
    localparam int unsigned PRI_W  = (PRIORITY > 1) ? $clog2(PRIORITY) : 1;
    localparam int unsigned BIN_W  = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;

    logic                      i_clear;
    logic [PORT-1:0]           i_wr;
    logic [PORT*PRIORITY-1:0]  i_wr_priority;
    logic [PORT-1:0]           i_rd;
    logic [PORT*PRIORITY-1:0]  i_rd_priority;
    logic [PORT*WIDTH-1:0]     i_data;
    logic [WIDTH-1:0]          o_now;
    logic [PORT_W-1:0]         i_sel_port;
    logic [PRI_W-1:0]          i_sel_pri;
    logic [BIN_W-1:0]          i_sel_bin;
    logic [WIDTH-1:0]          o_cnt_in;
    logic [WIDTH-1:0]          o_cnt_out;
    logic [WIDTH-1:0]          o_min_delay;
    logic [WIDTH-1:0]          o_max_delay;
    logic [2*WIDTH-1:0]        o_total_delay;
    logic [WIDTH-1:0]          o_hist;
    logic                      o_err;

    modport master (
        output i_clear, i_wr, i_wr_priority, i_rd, i_rd_priority, i_data,
               i_sel_port, i_sel_pri, i_sel_bin,
        input  o_now, o_cnt_in, o_cnt_out, o_min_delay, o_max_delay, o_total_delay,
               o_hist, o_err
    );

    modport slave (
        input  i_clear, i_wr, i_wr_priority, i_rd, i_rd_priority, i_data,
               i_sel_port, i_sel_pri, i_sel_bin,
        output o_now, o_cnt_in, o_cnt_out, o_min_delay, o_max_delay, o_total_delay,
               o_hist, o_err
    );
endinterface

// File: rtl/vpq_delay_port_stats.sv
// Per-port statistics: PRIORITY stat records plus optional delay histogram
// (VPQ_DELAY_HIST_EN). Selected record/bin is presented combinationally.
module vpq_delay_port_stats
    import vpq_stats_pkg::*;
#(
    parameter int unsigned PRIORITY   = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HIST_BINS  = 8,
    parameter int unsigned HIST_SHIFT = 3,
    localparam int unsigned PRI_W = (PRIORITY > 1) ? $clog2(PRIORITY) : 1,
    localparam int unsigned BIN_W = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr,
    input  logic [PRIORITY-1:0] wr_pri,
    input  logic                rd,
    input  logic [PRIORITY-1:0] rd_pri,
    input  logic [WIDTH-1:0]    data,
    input  logic [WIDTH-1:0]    now,
    input  logic [PRI_W-1:0]    sel_pri,
    input  logic [BIN_W-1:0]    sel_bin,
    output stat_rec_t           sel_rec,
    output logic [WIDTH-1:0]    sel_hist,
    output logic                bad
);
    stat_rec_t        rec     [PRIORITY];
    stat_rec_t        rec_nxt [PRIORITY];
    logic [31:0]      wr_pri_x;
    logic [31:0]      rd_pri_x;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] delay;
    stat_w_t          delay_x;

    always_comb begin
        wr_pri_x                 = '0;
        wr_pri_x[PRIORITY-1:0]   = wr_pri;
        rd_pri_x                 = '0;
        rd_pri_x[PRIORITY-1:0]   = rd_pri;
        wr_ok   = wr && onehot_valid(wr_pri_x);
        rd_ok   = rd && onehot_valid(rd_pri_x);
        bad     = (wr && !onehot_valid(wr_pri_x)) || (rd && !onehot_valid(rd_pri_x));
        // modular subtraction keeps the delay correct across time-base wrap
        delay   = now - data;
        delay_x = '0;
        delay_x[WIDTH-1:0] = delay;
    end

    always_comb begin
        rec_nxt = rec;
        for (int unsigned p = 0; p < PRIORITY; p++) begin
            if (wr_ok && wr_pri[p]) rec_nxt[p].cnt_in = sat_inc(rec[p].cnt_in, WIDTH);
            if (rd_ok && rd_pri[p]) begin
                rec_nxt[p].cnt_out = sat_inc(rec[p].cnt_out, WIDTH);
                rec_nxt[p].total   = sat_acc(rec[p].total, delay_x, 2 * WIDTH);
                if (delay_x < rec[p].min_d) rec_nxt[p].min_d = delay_x;
                if (delay_x > rec[p].max_d) rec_nxt[p].max_d = delay_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int unsigned p = 0; p < PRIORITY; p++) rec[p] <= rec_init(WIDTH);
        end else begin
            rec <= rec_nxt;
        end
    end

    assign sel_rec = rec[sel_pri];

`ifdef VPQ_DELAY_HIST_EN
    logic [WIDTH-1:0] hist [PRIORITY][HIST_BINS];
    logic [WIDTH-1:0] shifted;
    logic [BIN_W-1:0] bin;

    always_comb begin
        shifted = delay >> HIST_SHIFT;
        if (shifted > WIDTH'(HIST_BINS - 1)) bin = BIN_W'(HIST_BINS - 1);
        else                                 bin = shifted[BIN_W-1:0];
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < PRIORITY; p++) begin
            for (int unsigned b = 0; b < HIST_BINS; b++) begin
                if (reset || clear) begin
                    hist[p][b] <= '0;
                end else if (rd_ok && rd_pri[p] && (bin == BIN_W'(b)) && (hist[p][b] != '1)) begin
                    hist[p][b] <= hist[p][b] + WIDTH'(1);
                end
            end
        end
    end

    assign sel_hist = hist[sel_pri][sel_bin];
`else
    logic unused_bin;
    assign unused_bin = ^sel_bin;
    assign sel_hist   = '0;
`endif

endmodule

// File: rtl/vpq_delay_monitor.sv
// Per-port/per-priority VPQ latency monitor: time base, sticky error, registered readout.
// Optional histogram enabled with VPQ_DELAY_HIST_EN.
module vpq_delay_monitor
    import vpq_stats_pkg::*;
#(
    parameter int unsigned PORT       = 8,
    parameter int unsigned PRIORITY   = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HIST_BINS  = 8,
    parameter int unsigned HIST_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    vpq_delay_monitor_if.slave   bus
);
    logic [WIDTH-1:0]   now;
    logic               err;
    stat_rec_t          rec_sel  [PORT];
    logic [WIDTH-1:0]   hist_sel [PORT];
    logic [PORT-1:0]    bad;
    stat_rec_t          sel;
    logic [WIDTH-1:0]   sel_hist;
    logic [WIDTH-1:0]   cnt_in_q, cnt_out_q, min_q, max_q, hist_q;
    logic [2*WIDTH-1:0] total_q;

    for (genvar i = 0; i < PORT; i++) begin : g_port
        vpq_delay_port_stats #(
            .PRIORITY   (PRIORITY),
            .WIDTH      (WIDTH),
            .HIST_BINS  (HIST_BINS),
            .HIST_SHIFT (HIST_SHIFT)
        ) u_stats (
            .clk      (clk),
            .reset    (reset),
            .clear    (bus.i_clear),
            .wr       (bus.i_wr[i]),
            .wr_pri   (bus.i_wr_priority[i*PRIORITY +: PRIORITY]),
            .rd       (bus.i_rd[i]),
            .rd_pri   (bus.i_rd_priority[i*PRIORITY +: PRIORITY]),
            .data     (bus.i_data[i*WIDTH +: WIDTH]),
            .now      (now),
            .sel_pri  (bus.i_sel_pri),
            .sel_bin  (bus.i_sel_bin),
            .sel_rec  (rec_sel[i]),
            .sel_hist (hist_sel[i]),
            .bad      (bad[i])
        );
    end

    always_comb begin
        sel      = rec_sel[bus.i_sel_port];
        sel_hist = hist_sel[bus.i_sel_port];
    end

    always_ff @(posedge clk) begin
        if (reset) now <= '0;
        else       now <= now + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.i_clear) err <= 1'b0;
        else if (|bad)            err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            min_q     <= '1;
            max_q     <= '0;
            total_q   <= '0;
            hist_q    <= '0;
        end else begin
            cnt_in_q  <= sel.cnt_in[WIDTH-1:0];
            cnt_out_q <= sel.cnt_out[WIDTH-1:0];
            min_q     <= sel.min_d[WIDTH-1:0];
            max_q     <= sel.max_d[WIDTH-1:0];
            total_q   <= sel.total[2*WIDTH-1:0];
            hist_q    <= sel_hist;
        end
    end

    assign bus.o_now         = now;
    assign bus.o_err         = err;
    assign bus.o_cnt_in      = cnt_in_q;
    assign bus.o_cnt_out     = cnt_out_q;
    assign bus.o_min_delay   = min_q;
    assign bus.o_max_delay   = max_q;
    assign bus.o_total_delay = total_q;
    assign bus.o_hist        = hist_q;

endmodule

// File: tb/tb_vpq_delay_monitor.sv
// Scoreboard bench for vpq_delay_monitor: a full-size instance plus a WIDTH=8 instance
// that reaches counter/total saturation in a few hundred cycles.
module tb_vpq_delay_monitor;

`ifdef VPQ_DELAY_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vpq_delay_monitor_if #(.PORT(8), .PRIORITY(4), .WIDTH(32), .HIST_BINS(8)) bus ();
    vpq_delay_monitor_if #(.PORT(2), .PRIORITY(2), .WIDTH(8),  .HIST_BINS(8)) sbus ();

    vpq_delay_monitor #(.PORT(8), .PRIORITY(4), .WIDTH(32), .HIST_BINS(8), .HIST_SHIFT(3)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    vpq_delay_monitor #(.PORT(2), .PRIORITY(2), .WIDTH(8), .HIST_BINS(8), .HIST_SHIFT(3)) dut_s (
        .clk   (clk),
        .reset (rst),
        .bus   (sbus.slave)
    );

    typedef struct {
        int          inst;
        bit          is_now;
        string       name;
        logic [31:0] now;
        logic [31:0] cin;
        logic [31:0] cout;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [63:0] tot;
        logic [31:0] hist;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   chk_req = 1'b0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: a check request seen at a clock edge is compared at the following negedge.
    always @(posedge clk) begin
        if (chk_req) begin
            exp_t e;
            @(negedge clk);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: check requested with empty queue");
            end else begin
                e = sb.pop_front();
                if (e.is_now) begin
                    cmp({e.name, ".now"}, {32'd0, bus.o_now}, {32'd0, e.now});
                end else if (e.inst == 0) begin
                    cmp({e.name, ".cnt_in"},  {32'd0, bus.o_cnt_in},    {32'd0, e.cin});
                    cmp({e.name, ".cnt_out"}, {32'd0, bus.o_cnt_out},   {32'd0, e.cout});
                    cmp({e.name, ".min"},     {32'd0, bus.o_min_delay}, {32'd0, e.mn});
                    cmp({e.name, ".max"},     {32'd0, bus.o_max_delay}, {32'd0, e.mx});
                    cmp({e.name, ".total"},   bus.o_total_delay,        e.tot);
                    cmp({e.name, ".hist"},    {32'd0, bus.o_hist},      {32'd0, e.hist});
                    cmp({e.name, ".err"},     {63'd0, bus.o_err},       {63'd0, e.err});
                end else begin
                    cmp({e.name, ".cnt_in"},  {56'd0, sbus.o_cnt_in},    {32'd0, e.cin});
                    cmp({e.name, ".cnt_out"}, {56'd0, sbus.o_cnt_out},   {32'd0, e.cout});
                    cmp({e.name, ".min"},     {56'd0, sbus.o_min_delay}, {32'd0, e.mn});
                    cmp({e.name, ".max"},     {56'd0, sbus.o_max_delay}, {32'd0, e.mx});
                    cmp({e.name, ".total"},   {48'd0, sbus.o_total_delay}, e.tot);
                    cmp({e.name, ".hist"},    {56'd0, sbus.o_hist},      {32'd0, e.hist});
                    cmp({e.name, ".err"},     {63'd0, sbus.o_err},       {63'd0, e.err});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic idle();
        bus.i_clear        = 1'b0;
        bus.i_wr           = '0;
        bus.i_wr_priority  = '0;
        bus.i_rd           = '0;
        bus.i_rd_priority  = '0;
        bus.i_data         = '0;
        sbus.i_clear       = 1'b0;
        sbus.i_wr          = '0;
        sbus.i_wr_priority = '0;
        sbus.i_rd          = '0;
        sbus.i_rd_priority = '0;
        sbus.i_data        = '0;
    endtask

    task automatic wr_evt(input int port, input logic [3:0] pri);
        bus.i_wr[port] = 1'b1;
        bus.i_wr_priority[port*4 +: 4] = pri;
    endtask

    task automatic rd_evt(input int port, input logic [3:0] pri, input logic [31:0] d);
        bus.i_rd[port] = 1'b1;
        bus.i_rd_priority[port*4 +: 4] = pri;
        bus.i_data[port*32 +: 32] = d;
    endtask

    task automatic wait_now(input logic [31:0] t);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.o_now == t) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL wait_now: o_now 0x%0h, required 0x%0h", bus.o_now, t);
        end
    endtask

    task automatic expect_now(input logic [31:0] v, input string nm);
        exp_t e;
        e = '{inst: 0, is_now: 1'b1, name: nm, now: v, cin: 0, cout: 0, mn: 0, mx: 0,
              tot: 0, hist: 0, err: 1'b0};
        sb.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic check(input int inst, input int port, input int pri, input int bin,
                         input string nm, input logic [31:0] cin, input logic [31:0] cout,
                         input logic [31:0] mn, input logic [31:0] mx, input logic [63:0] tot,
                         input logic [31:0] hs, input bit er);
        exp_t e;
        if (inst == 0) begin
            bus.i_sel_port = port[2:0];
            bus.i_sel_pri  = pri[1:0];
            bus.i_sel_bin  = bin[2:0];
        end else begin
            sbus.i_sel_port = port[0:0];
            sbus.i_sel_pri  = pri[0:0];
            sbus.i_sel_bin  = bin[2:0];
        end
        e = '{inst: inst, is_now: 1'b0, name: nm, now: 0, cin: cin, cout: cout, mn: mn,
              mx: mx, tot: tot, hist: hs, err: er};
        sb.push_back(e);
        chk_req = 1'b1;
        tick();
    endtask

    task automatic check_rst(input int port, input int pri, input string nm, input bit er);
        check(0, port, pri, 0, nm, 0, 0, 32'hffff_ffff, 0, 0, 0, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.i_sel_port = '0; bus.i_sel_pri = '0; bus.i_sel_bin = '0;
        sbus.i_sel_port = '0; sbus.i_sel_pri = '0; sbus.i_sel_bin = '0;
        tick();
        tick();
        expect_now(0, "now_in_reset");
        tick();
        rst = 1'b0;
        expect_now(1, "now_1");
        tick();
        expect_now(2, "now_2");
        tick();
        expect_now(3, "now_3");
        tick();

        check_rst(0, 0, "rst_p0q0", 1'b0);
        check_rst(7, 3, "rst_p7q3", 1'b0);
        check(1, 1, 1, 0, "rst_small", 0, 0, 32'hff, 0, 0, 0, 1'b0);

        // Port 2 pri 1: enqueue at now=10, dequeue stamp 10 at now=25 -> delay 15 (bin 1)
        wait_now(10);
        wr_evt(2, 4'b0010);
        tick();
        idle();
        wait_now(25);
        rd_evt(2, 4'b0010, 32'd10);
        tick();
        idle();
        check(0, 2, 1, 1, "p2q1_first", 1, 1, 15, 15, 15, HIST_ON ? 1 : 0, 1'b0);
        check_rst(2, 0, "p2q0_untouched", 1'b0);

        // Simultaneous wr+rd on port 2 pri 1, delay 5 (bin 0)
        wait_now(50);
        wr_evt(2, 4'b0010);
        rd_evt(2, 4'b0010, 32'd45);
        tick();
        idle();
        check(0, 2, 1, 0, "p2q1_second", 2, 2, 5, 15, 20, HIST_ON ? 1 : 0, 1'b0);

        // All ports dequeue on pri 3 in one cycle with delays 1..8
        wait_now(60);
        for (int i = 0; i < 8; i++) rd_evt(i, 4'b1000, 32'd60 - 32'(i + 1));
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            check(0, i, 3, 0, $sformatf("allport_p%0d", i), 0, 1, 32'(i + 1), 32'(i + 1),
                  64'(i + 1), (HIST_ON && i < 7) ? 1 : 0, 1'b0);
        end

        // Multi-hot priority: event dropped, sticky error
        rd_evt(4, 4'b0110, 32'd0);
        tick();
        idle();
        check_rst(4, 1, "multihot_q1", 1'b1);
        check_rst(4, 2, "multihot_q2", 1'b1);
        check(0, 4, 3, 0, "multihot_q3", 0, 1, 5, 5, 5, HIST_ON ? 1 : 0, 1'b1);
        wr_evt(3, 4'b0000);
        tick();
        idle();
        check_rst(3, 0, "zerohot_wr", 1'b1);

        // Clear with a dequeue in the same cycle; time base keeps running
        wait_now(100);
        bus.i_clear = 1'b1;
        rd_evt(0, 4'b1000, 32'd90);
        expect_now(101, "now_through_clear");
        tick();
        idle();
        check_rst(0, 3, "clear_p0q3", 1'b0);
        check_rst(2, 1, "clear_p2q1", 1'b0);

        // Reset mid-operation
        wait_now(110);
        rd_evt(5, 4'b0001, 32'd100);
        tick();
        idle();
        check(0, 5, 0, 1, "p5q0_pre_reset", 0, 1, 10, 10, 10, HIST_ON ? 1 : 0, 1'b0);
        rst = 1'b1;
        expect_now(0, "now_mid_reset");
        tick();
        rst = 1'b0;
        check_rst(5, 0, "p5q0_post_reset", 1'b0);

        // Time-base wrap: stamp 0xfffffff0 read at now=0x10 -> delay 0x20 (bin 4)
        wait_now(32'h10);
        rd_evt(6, 4'b0100, 32'hffff_fff0);
        tick();
        idle();
        check(0, 6, 2, 4, "wrap_delay", 0, 1, 32'h20, 32'h20, 64'h20, HIST_ON ? 1 : 0, 1'b0);

        // Delays 3, 9, 200 on port 1 pri 0 -> bins 0, 1, 7
        wait_now(40);
        rd_evt(1, 4'b0001, 32'd40 - 32'd3);
        tick();
        rd_evt(1, 4'b0001, 32'd41 - 32'd9);
        tick();
        rd_evt(1, 4'b0001, 32'd42 - 32'd200);
        tick();
        idle();
        check(0, 1, 0, 0, "hist_bin0", 0, 3, 3, 200, 212, HIST_ON ? 1 : 0, 1'b0);
        check(0, 1, 0, 1, "hist_bin1", 0, 3, 3, 200, 212, HIST_ON ? 1 : 0, 1'b0);
        check(0, 1, 0, 7, "hist_bin7", 0, 3, 3, 200, 212, HIST_ON ? 1 : 0, 1'b0);
        check(0, 1, 0, 3, "hist_bin3", 0, 3, 3, 200, 212, 0, 1'b0);

        // Saturation on the 8-bit instance: 400 wr+rd events of delay 200
        for (int i = 0; i < 400; i++) begin
            sbus.i_wr[1] = 1'b1;
            sbus.i_wr_priority[3:2] = 2'b01;
            sbus.i_rd[1] = 1'b1;
            sbus.i_rd_priority[3:2] = 2'b01;
            sbus.i_data[15:8] = sbus.o_now - 8'd200;
            tick();
        end
        idle();
        check(1, 1, 0, 7, "sat_small", 32'hff, 32'hff, 32'hc8, 32'hc8, 64'hffff,
              HIST_ON ? 32'hff : 0, 1'b0);
        check(1, 0, 1, 0, "sat_small_other", 0, 0, 32'hff, 0, 0, 0, 1'b0);

        tick();
        tick();
        tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
